// File: rtl/jtpopeye_loader_pkg.sv
// ============================================================================
// Module     : jtpopeye_loader_pkg
// Description: Shared types and colour PROM region map for the PROM loader.
// Revision   : 1.0 - initial release
// ============================================================================
`default_nettype none

package jtpopeye_loader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } loader_state_t;

    // Offsets are relative to the first byte of the colour PROM region
    localparam logic [21:0] OFF_4A  = 22'h000;
    localparam logic [21:0] OFF_3A  = 22'h020;
    localparam logic [21:0] OFF_5B  = 22'h040;
    localparam logic [21:0] OFF_5A  = 22'h140;
    localparam logic [21:0] OFF_END = 22'h240;

endpackage

`default_nettype wire

// File: rtl/jtpopeye_loader_sdpack.sv
// ============================================================================
// Module     : jtpopeye_loader_sdpack
// Description: Pairs download bytes into 16-bit SDRAM words; req/ack handshake
//              with sticky overflow when a word lands on a pending request.
// Revision   : 1.0 - initial release
// ============================================================================
`default_nettype none

module jtpopeye_loader_sdpack #(
    parameter int SDRAM_AW = 21
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_wr,
    input  logic [21:0]         i_addr,
    input  logic [7:0]          i_data,
    input  logic                i_flush,
    input  logic                i_clear,
    input  logic                i_ack,
    output logic [SDRAM_AW-1:0] o_addr,
    output logic [15:0]         o_data,
    output logic                o_req,
    output logic                o_overflow,
    output logic                o_busy
);

    logic [7:0]          r_even_data;
    logic [SDRAM_AW-1:0] r_even_addr;
    logic                r_even_valid;
    logic [SDRAM_AW-1:0] r_addr;
    logic [15:0]         r_data;
    logic                r_req;
    logic                r_overflow;

    logic                w_slot_free;
    logic                w_word;
    logic                w_even;
    logic                w_flush_go;
    logic [SDRAM_AW-1:0] w_waddr;

    always_comb begin
        w_slot_free = !r_req || i_ack;
        w_word      = i_wr && i_addr[0];
        w_even      = i_wr && !i_addr[0];
        w_flush_go  = i_flush && r_even_valid && w_slot_free;
        w_waddr     = SDRAM_AW'(i_addr >> 1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_even_data  <= 8'h00;
            r_even_addr  <= '0;
            r_even_valid <= 1'b0;
            r_addr       <= '0;
            r_data       <= 16'h0000;
            r_req        <= 1'b0;
            r_overflow   <= 1'b0;
        end else begin
            if (i_ack && r_req)
                r_req <= 1'b0;

            if (w_word) begin
                r_even_valid <= 1'b0;
                if (w_slot_free) begin
                    r_addr <= w_waddr;
                    r_data <= {i_data, r_even_data};
                    r_req  <= 1'b1;
                end else begin
                    r_overflow <= 1'b1;
                end
            end else if (w_flush_go) begin
                // Trailing even byte: its odd partner never arrived
                r_addr       <= r_even_addr;
                r_data       <= {8'h00, r_even_data};
                r_req        <= 1'b1;
                r_even_valid <= 1'b0;
            end

            if (w_even) begin
                r_even_data  <= i_data;
                r_even_addr  <= w_waddr;
                r_even_valid <= 1'b1;
            end

            if (i_clear) begin
                r_overflow   <= 1'b0;
                r_even_valid <= 1'b0;
                r_even_data  <= 8'h00;
            end
        end
    end

    assign o_addr     = r_addr;
    assign o_data     = r_data;
    assign o_req      = r_req;
    assign o_overflow = r_overflow;
    assign o_busy     = r_req || r_even_valid;

endmodule

`default_nettype wire

// File: rtl/jtpopeye_prom_loader.sv
// ============================================================================
// Module     : jtpopeye_prom_loader
// Description: Decodes the ROM download stream into colour PROM writes and
//              packed SDRAM words. Optional JTPOPEYE_LOADER_CHKSUM_EN adds a
//              16-bit byte checksum output.
// Revision   : 1.0 - initial release
// ============================================================================
`default_nettype none

module jtpopeye_prom_loader
    import jtpopeye_loader_pkg::*;
#(
    parameter logic [21:0] PROM_START = 22'h1_8000,
    parameter int          SDRAM_AW   = 21
) (
    input  logic                rst_n,
    input  logic                clk,
    input  logic                downloading,
    input  logic [21:0]         ioctl_addr,
    input  logic [7:0]          ioctl_data,
    input  logic                ioctl_wr,
    output logic [7:0]          prog_addr,
    output logic [7:0]          prom_din,
    output logic                prom_4a_we,
    output logic                prom_3a_we,
    output logic                prom_5b_we,
    output logic                prom_5a_we,
    output logic [SDRAM_AW-1:0] sdram_addr,
    output logic [15:0]         sdram_data,
    output logic                sdram_req,
    input  logic                sdram_ack,
    output logic                loaded,
`ifdef JTPOPEYE_LOADER_CHKSUM_EN
    output logic [15:0]         chksum,
`endif
    output logic                overflow
);

    loader_state_t r_state;
    loader_state_t w_next;
    logic          r_dl_prev;
    logic          r_loaded;
    logic [7:0]    r_prog_addr;
    logic [7:0]    r_prom_din;
    logic [3:0]    r_we;

    logic          w_dl_rise;
    logic          w_acc;
    logic          w_is_prom;
    logic [21:0]   w_off;
    logic [3:0]    w_sel;
    logic [7:0]    w_rel;
    logic          w_sd_busy;

    assign w_dl_rise = downloading && !r_dl_prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_dl_prev <= 1'b0;
            r_loaded  <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_dl_prev <= downloading;
            r_loaded  <= (r_state == ST_DONE) && !w_dl_rise;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  w_next = ST_IDLE;
            ST_LOAD:  if (!downloading) w_next = ST_FLUSH;
            ST_FLUSH: if (!w_sd_busy)   w_next = ST_DONE;
            ST_DONE:  w_next = ST_DONE;
            default:  w_next = ST_IDLE;
        endcase
        if (w_dl_rise)
            w_next = ST_LOAD;
    end

    // Region decode; w_sel is {4a, 3a, 5b, 5a}
    always_comb begin
        w_acc     = ioctl_wr && (r_state == ST_LOAD);
        w_is_prom = ioctl_addr >= PROM_START;
        w_off     = ioctl_addr - PROM_START;
        w_sel     = 4'b0000;
        w_rel     = 8'h00;
        if (w_off < OFF_3A) begin
            w_sel = 4'b1000;
            w_rel = 8'(w_off - OFF_4A);
        end else if (w_off < OFF_5B) begin
            w_sel = 4'b0100;
            w_rel = 8'(w_off - OFF_3A);
        end else if (w_off < OFF_5A) begin
            w_sel = 4'b0010;
            w_rel = 8'(w_off - OFF_5B);
        end else if (w_off < OFF_END) begin
            w_sel = 4'b0001;
            w_rel = 8'(w_off - OFF_5A);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prog_addr <= 8'h00;
            r_prom_din  <= 8'h00;
            r_we        <= 4'b0000;
        end else begin
            r_we <= 4'b0000;
            if (w_acc && w_is_prom && (w_sel != 4'b0000)) begin
                r_we        <= w_sel;
                r_prog_addr <= w_rel;
                r_prom_din  <= ioctl_data;
            end
        end
    end

    jtpopeye_loader_sdpack #(
        .SDRAM_AW (SDRAM_AW)
    ) u_sdpack (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_wr       (w_acc && !w_is_prom),
        .i_addr     (ioctl_addr),
        .i_data     (ioctl_data),
        .i_flush    (r_state == ST_FLUSH),
        .i_clear    (w_dl_rise),
        .i_ack      (sdram_ack),
        .o_addr     (sdram_addr),
        .o_data     (sdram_data),
        .o_req      (sdram_req),
        .o_overflow (overflow),
        .o_busy     (w_sd_busy)
    );

`ifdef JTPOPEYE_LOADER_CHKSUM_EN
    logic [15:0] r_chksum;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_chksum <= 16'h0000;
        else if (w_dl_rise)
            r_chksum <= 16'h0000;
        else if (w_acc)
            r_chksum <= r_chksum + {8'h00, ioctl_data};
    end

    assign chksum = r_chksum;
`endif

    assign prog_addr  = r_prog_addr;
    assign prom_din   = r_prom_din;
    assign prom_4a_we = r_we[3];
    assign prom_3a_we = r_we[2];
    assign prom_5b_we = r_we[1];
    assign prom_5a_we = r_we[0];
    assign loaded     = r_loaded;

endmodule

`default_nettype wire

// File: tb/tb_jtpopeye_prom_loader.sv
// ============================================================================
// Module     : tb_jtpopeye_prom_loader
// Description: Scoreboard bench for the colour PROM / SDRAM download loader.
// Revision   : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_jtpopeye_prom_loader;

    localparam logic [21:0] PROM_START = 22'h1_8000;
    localparam int          SDRAM_AW   = 21;

    logic                rst_n;
    logic                clk;
    logic                downloading;
    logic [21:0]         ioctl_addr;
    logic [7:0]          ioctl_data;
    logic                ioctl_wr;
    logic [7:0]          prog_addr;
    logic [7:0]          prom_din;
    logic                prom_4a_we;
    logic                prom_3a_we;
    logic                prom_5b_we;
    logic                prom_5a_we;
    logic [SDRAM_AW-1:0] sdram_addr;
    logic [15:0]         sdram_data;
    logic                sdram_req;
    logic                sdram_ack;
    logic                loaded;
    logic                overflow;
`ifdef JTPOPEYE_LOADER_CHKSUM_EN
    logic [15:0]         chksum;
`endif

    typedef struct packed {
        logic [3:0] sel;
        logic [7:0] addr;
        logic [7:0] data;
    } prom_exp_t;

    typedef struct packed {
        logic [SDRAM_AW-1:0] addr;
        logic [15:0]         data;
    } sd_exp_t;

    prom_exp_t prom_q[$];
    sd_exp_t   sd_q[$];

    int n_total = 0;
    int n_bad   = 0;

    jtpopeye_prom_loader #(
        .PROM_START (PROM_START),
        .SDRAM_AW   (SDRAM_AW)
    ) dut (
        .rst_n       (rst_n),
        .clk         (clk),
        .downloading (downloading),
        .ioctl_addr  (ioctl_addr),
        .ioctl_data  (ioctl_data),
        .ioctl_wr    (ioctl_wr),
        .prog_addr   (prog_addr),
        .prom_din    (prom_din),
        .prom_4a_we  (prom_4a_we),
        .prom_3a_we  (prom_3a_we),
        .prom_5b_we  (prom_5b_we),
        .prom_5a_we  (prom_5a_we),
        .sdram_addr  (sdram_addr),
        .sdram_data  (sdram_data),
        .sdram_req   (sdram_req),
        .sdram_ack   (sdram_ack),
        .loaded      (loaded),
`ifdef JTPOPEYE_LOADER_CHKSUM_EN
        .chksum      (chksum),
`endif
        .overflow    (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // PROM write monitor: every strobe must match the next expected write
    always @(negedge clk) begin
        if (rst_n) begin
            if (prom_4a_we || prom_3a_we || prom_5b_we || prom_5a_we) begin
                if (prom_q.size() == 0) begin
                    chk("prom_unexpected_we", {60'd0, prom_4a_we, prom_3a_we, prom_5b_we, prom_5a_we}, 64'd0);
                end else begin
                    prom_exp_t e;
                    e = prom_q.pop_front();
                    chk("prom_we", {60'd0, prom_4a_we, prom_3a_we, prom_5b_we, prom_5a_we}, {60'd0, e.sel});
                    chk("prog_addr", {56'd0, prog_addr}, {56'd0, e.addr});
                    chk("prom_din", {56'd0, prom_din}, {56'd0, e.data});
                end
            end
        end
    end

    task automatic write_byte(input logic [21:0] a, input logic [7:0] d);
        @(posedge clk); #1;
        ioctl_wr   = 1'b1;
        ioctl_addr = a;
        ioctl_data = d;
        @(posedge clk); #1;
        ioctl_wr   = 1'b0;
    endtask

    task automatic wait_req(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (sdram_req) begin
                ok = 1'b1;
                return;
            end
        end
        chk("sdram_req_timeout", 64'd0, 64'd1);
    endtask

    task automatic sd_compare();
        sd_exp_t e;
        if (sd_q.size() == 0) begin
            chk("sdram_unexpected_req", {63'd0, sdram_req}, 64'd0);
        end else begin
            e = sd_q.pop_front();
            chk("sdram_addr", {43'd0, sdram_addr}, {43'd0, e.addr});
            chk("sdram_data", {48'd0, sdram_data}, {48'd0, e.data});
        end
    endtask

    task automatic sd_ack_pulse();
        @(posedge clk); #1;
        sdram_ack = 1'b1;
        @(posedge clk); #1;
        sdram_ack = 1'b0;
        @(negedge clk);
        chk("req_drop_after_ack", {63'd0, sdram_req}, 64'd0);
    endtask

    task automatic sd_expect_and_ack();
        bit ok;
        wait_req(ok);
        if (ok) begin
            sd_compare();
            sd_ack_pulse();
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(posedge clk);
        #1;
    endtask

    logic [21:0] tbl_off  [8];
    logic [7:0]  tbl_data [8];
    logic [3:0]  tbl_sel  [8];
    logic [7:0]  tbl_rel  [8];

    initial begin
        bit ok;
        rst_n       = 1'b0;
        downloading = 1'b0;
        ioctl_addr  = 22'd0;
        ioctl_data  = 8'd0;
        ioctl_wr    = 1'b0;
        sdram_ack   = 1'b0;

        tbl_off[0] = 22'h025; tbl_data[0] = 8'h5A; tbl_sel[0] = 4'b0100; tbl_rel[0] = 8'h05;
        tbl_off[1] = 22'h000; tbl_data[1] = 8'h11; tbl_sel[1] = 4'b1000; tbl_rel[1] = 8'h00;
        tbl_off[2] = 22'h01F; tbl_data[2] = 8'h22; tbl_sel[2] = 4'b1000; tbl_rel[2] = 8'h1F;
        tbl_off[3] = 22'h040; tbl_data[3] = 8'h03; tbl_sel[3] = 4'b0010; tbl_rel[3] = 8'h00;
        tbl_off[4] = 22'h13F; tbl_data[4] = 8'h0C; tbl_sel[4] = 4'b0010; tbl_rel[4] = 8'hFF;
        tbl_off[5] = 22'h140; tbl_data[5] = 8'h07; tbl_sel[5] = 4'b0001; tbl_rel[5] = 8'h00;
        tbl_off[6] = 22'h23F; tbl_data[6] = 8'h0E; tbl_sel[6] = 4'b0001; tbl_rel[6] = 8'hFF;
        tbl_off[7] = 22'h240; tbl_data[7] = 8'h99; tbl_sel[7] = 4'b0000; tbl_rel[7] = 8'h00;

        idle(3);
        chk("reset_outputs",
            {4'd0, prog_addr, prom_din, prom_4a_we, prom_3a_we, prom_5b_we, prom_5a_we,
             sdram_addr, sdram_data, sdram_req, loaded, overflow}, 64'd0);
        rst_n = 1'b1;
        idle(2);

        downloading = 1'b1;
        idle(2);

        // PROM region decode including boundaries and the ignored tail
        for (int i = 0; i < 8; i++) begin
            if (tbl_sel[i] != 4'b0000)
                prom_q.push_back('{sel: tbl_sel[i], addr: tbl_rel[i], data: tbl_data[i]});
            write_byte(PROM_START + tbl_off[i], tbl_data[i]);
        end
        idle(3);
        chk("prom_queue_drained", 64'(prom_q.size()), 64'd0);

        // Basic word pack and handshake
        sd_q.push_back('{addr: 21'd0, data: 16'h3412});
        write_byte(22'h00000, 8'h12);
        write_byte(22'h00001, 8'h34);
        sd_expect_and_ack();

        // New word completes on the same cycle as the ack
        sd_q.push_back('{addr: 21'd3, data: 16'hC2C1});
        write_byte(22'h00006, 8'hC1);
        write_byte(22'h00007, 8'hC2);
        wait_req(ok);
        if (ok) sd_compare();
        write_byte(22'h00008, 8'hD1);
        @(posedge clk); #1;
        ioctl_wr   = 1'b1;
        ioctl_addr = 22'h00009;
        ioctl_data = 8'hD2;
        sdram_ack  = 1'b1;
        @(posedge clk); #1;
        ioctl_wr   = 1'b0;
        sdram_ack  = 1'b0;
        @(negedge clk);
        chk("ack_and_word_no_overflow", {63'd0, overflow}, 64'd0);
        sd_q.push_back('{addr: 21'd4, data: 16'hD2D1});
        sd_expect_and_ack();

        // Word arrives while the previous request is still pending
        sd_q.push_back('{addr: 21'd1, data: 16'h7856});
        write_byte(22'h00002, 8'h56);
        write_byte(22'h00003, 8'h78);
        write_byte(22'h00004, 8'h9A);
        write_byte(22'h00005, 8'hBC);
        @(negedge clk);
        chk("overflow_set", {63'd0, overflow}, 64'd1);
        chk("overflow_data_kept", {48'd0, sdram_data}, 64'h7856);
        sd_expect_and_ack();

        // Lone even byte flushed at end of download
        sd_q.push_back('{addr: 21'd2, data: 16'h00AB});
        write_byte(22'h00004, 8'hAB);
        @(posedge clk); #1;
        downloading = 1'b0;
        wait_req(ok);
        if (ok) begin
            chk("loaded_before_ack", {63'd0, loaded}, 64'd0);
            sd_compare();
            sd_ack_pulse();
        end
        idle(4);
        chk("loaded_after_flush", {63'd0, loaded}, 64'd1);
        chk("overflow_sticky_done", {63'd0, overflow}, 64'd1);

        // Writes outside LOAD must do nothing
        write_byte(PROM_START, 8'h55);
        write_byte(22'h00010, 8'h01);
        write_byte(22'h00011, 8'h02);
        idle(3);
        chk("no_req_outside_load", {63'd0, sdram_req}, 64'd0);

        // Restart download
        @(posedge clk); #1;
        downloading = 1'b1;
        idle(2);
        chk("loaded_cleared", {63'd0, loaded}, 64'd0);
        chk("overflow_cleared", {63'd0, overflow}, 64'd0);

`ifdef JTPOPEYE_LOADER_CHKSUM_EN
        write_byte(PROM_START + 22'h300, 8'hFF);
        write_byte(PROM_START + 22'h301, 8'h02);
        idle(1);
        chk("chksum", {48'd0, chksum}, 64'h0101);
`endif

        // Asynchronous reset with a request outstanding
        write_byte(22'h0000A, 8'h01);
        write_byte(22'h0000B, 8'h02);
        wait_req(ok);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset_outputs",
            {4'd0, prog_addr, prom_din, prom_4a_we, prom_3a_we, prom_5b_we, prom_5a_we,
             sdram_addr, sdram_data, sdram_req, loaded, overflow}, 64'd0);
`ifdef JTPOPEYE_LOADER_CHKSUM_EN
        chk("async_reset_chksum", {48'd0, chksum}, 64'd0);
`endif
        idle(2);
        rst_n = 1'b1;
        idle(2);

        chk("prom_queue_empty", 64'(prom_q.size()), 64'd0);
        chk("sdram_queue_empty", 64'(sd_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
